// File: rtl/fifo_window_reader_if.sv
// Handshake and data bundle between the window reader, its FIFO heads and its controller.
// The reader sits on the slave modport; the environment sits on the master modport.
interface fifo_window_reader_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned SumWidth  = DataWidth + 4
);
    logic                 Start;
    logic [15:0]          Length;
    logic                 Empty;
    logic [DataWidth-1:0] DataOut1;
    logic [DataWidth-1:0] DataOut2;
    logic                 Pop1;
    logic                 Pop2;
    logic [SumWidth-1:0]  Sum;
    logic                 SumValid;
    logic                 Busy;
    logic                 Done;
    logic                 Err;

    modport master (
        output Start, Length, Empty, DataOut1, DataOut2,
        input  Pop1, Pop2, Sum, SumValid, Busy, Done, Err
    );

    modport slave (
        input  Start, Length, Empty, DataOut1, DataOut2,
        output Pop1, Pop2, Sum, SumValid, Busy, Done, Err
    );
endinterface

// File: rtl/fifo_window_reader.sv
// Sliding-window sum over a FIFO read through two show-ahead heads lagging by WindowLen words.
// The plus-head feeds new words in, the minus-head retires the word leaving the window.
module fifo_window_reader #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned WindowLen = 4,
    parameter int unsigned SumWidth  = DataWidth + 4
) (
    input logic                  clk,
    input logic                  aclr,
    input logic                  clk_en,
    fifo_window_reader_if.slave  bus
);
    localparam logic [15:0] KLen   = 16'(WindowLen);
    localparam logic [15:0] KLast  = 16'(WindowLen - 1);
    localparam logic [3:0]  KDrain = 4'(WindowLen - 1);

    typedef enum logic [2:0] {StIdle, StFill, StSlide, StDrain, StFin} state_e;

    state_e              state_q, state_d;
    logic [SumWidth-1:0] sum_q, sum_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         plus_cnt_q, plus_cnt_d;
    logic [3:0]          drain_cnt_q, drain_cnt_d;
    logic                reject_q, reject_d;
    logic                sum_valid_q, sum_valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                pop1, pop2;

    function automatic logic [SumWidth-1:0] sext(input logic [DataWidth-1:0] d);
        return {{(SumWidth - DataWidth){d[DataWidth-1]}}, d};
    endfunction

    always_comb begin
        pop1 = clk_en & ~aclr & ~bus.Empty & ((state_q == StFill) | (state_q == StSlide))
             & (plus_cnt_q < len_q);
        // Both heads move together in SLIDE; DRAIN only retires the minus-head backlog.
        pop2 = ((state_q == StSlide) & pop1) | ((state_q == StDrain) & clk_en & ~aclr);
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        len_d       = len_q;
        plus_cnt_d  = plus_cnt_q;
        drain_cnt_d = drain_cnt_q;
        reject_d    = reject_q;
        sum_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    if (bus.Length < KLen) begin
                        reject_d = 1'b1;
                        state_d  = StFin;
                    end else begin
                        reject_d    = 1'b0;
                        len_d       = bus.Length;
                        sum_d       = '0;
                        plus_cnt_d  = '0;
                        drain_cnt_d = '0;
                        state_d     = StFill;
                    end
                end
            end
            StFill: begin
                if (pop1) begin
                    sum_d      = sum_q + sext(bus.DataOut1);
                    plus_cnt_d = plus_cnt_q + 16'd1;
                    if (plus_cnt_q == KLast) begin
                        sum_valid_d = 1'b1;
                        state_d     = StSlide;
                    end
                end
            end
            StSlide: begin
                if (pop1) begin
                    sum_d       = sum_q + sext(bus.DataOut1) - sext(bus.DataOut2);
                    plus_cnt_d  = plus_cnt_q + 16'd1;
                    sum_valid_d = 1'b1;
                    if (plus_cnt_d == len_q) state_d = StDrain;
                end else if (plus_cnt_q == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 4'd1;
                if (drain_cnt_q == KDrain) state_d = StFin;
            end
            StFin: begin
                done_d  = 1'b1;
                err_d   = reject_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            len_q       <= '0;
            plus_cnt_q  <= '0;
            drain_cnt_q <= '0;
            reject_q    <= 1'b0;
            sum_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            plus_cnt_q  <= plus_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            reject_q    <= reject_d;
            sum_valid_q <= sum_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Strobes frozen by a low clk_en are masked, then shown once enable returns.
    assign bus.Pop1     = pop1;
    assign bus.Pop2     = pop2;
    assign bus.Sum      = sum_q;
    assign bus.SumValid = sum_valid_q & clk_en;
    assign bus.Done     = done_q & clk_en;
    assign bus.Err      = err_q & clk_en;
    assign bus.Busy     = (state_q != StIdle);
endmodule

// File: tb/tb_fifo_window_reader.sv
// Bench for fifo_window_reader: a dual-head FIFO model feeds the DUT and window sums are
// predicted directly from the loaded word list.
module tb_fifo_window_reader;
    localparam int DW = 32;
    localparam int K  = 4;
    localparam int SW = DW + 4;

    logic clk = 1'b0;
    logic aclr;
    logic clk_en;
    always #5 clk = ~clk;

    fifo_window_reader_if #(.DataWidth(DW), .SumWidth(SW)) ifc ();

    fifo_window_reader #(.DataWidth(DW), .WindowLen(K), .SumWidth(SW)) dut (
        .clk    (clk),
        .aclr   (aclr),
        .clk_en (clk_en),
        .bus    (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] data_q [$];
    bit            stall_after [64];
    int            wr_cnt = 0;
    int            plus_ptr, minus_ptr, stall_cnt;
    logic [SW-1:0] got_q [$];
    logic [SW-1:0] exp_q [$];
    int            done_cnt = 0;
    logic          last_err = 1'b0;
    int            base_cycles, hold_cycles, dummy;

    assign ifc.Empty    = (plus_ptr >= wr_cnt) || (stall_cnt != 0);
    assign ifc.DataOut1 = mem[plus_ptr[5:0]];
    assign ifc.DataOut2 = mem[minus_ptr[5:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO heads; popping a marked word makes the plus-head look empty for 3 cycles.
    always @(posedge clk) begin
        if (aclr) begin
            plus_ptr  <= 0;
            minus_ptr <= 0;
            stall_cnt <= 0;
        end else begin
            if (ifc.Pop1) plus_ptr <= plus_ptr + 1;
            if (ifc.Pop2) minus_ptr <= minus_ptr + 1;
            if (ifc.Pop1 && stall_after[plus_ptr[5:0]]) stall_cnt <= 3;
            else if (stall_cnt != 0 && clk_en) stall_cnt <= stall_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (ifc.SumValid) got_q.push_back(ifc.Sum);
        if (ifc.Done) begin
            done_cnt++;
            last_err = ifc.Err;
        end
        if (ifc.Empty) chk("pop1_while_empty", 64'(ifc.Pop1), 64'd0);
        if (stall_cnt != 0) chk("pop2_while_stalled", 64'(ifc.Pop2), 64'd0);
        if (aclr || !clk_en) chk("pops_while_held", 64'({ifc.Pop1, ifc.Pop2}), 64'd0);
    end

    task automatic load();
        foreach (data_q[i]) mem[i] = data_q[i];
        wr_cnt = data_q.size();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 aclr = 1'b1;
        foreach (stall_after[i]) stall_after[i] = 1'b0;
        @(posedge clk);
        #1 aclr = 1'b0;
    endtask

    task automatic start(input int n);
        @(posedge clk);
        #1 ifc.Start = 1'b1;
        ifc.Length = 16'(n);
        @(posedge clk);
        #1 ifc.Start = 1'b0;
    endtask

    // Runs one pass and checks sums, pop totals and the end-of-pass flags against the model.
    task automatic run_pass(input int n, input bit hold, output int cycles);
        int  d0;
        bit  held;
        held = 1'b0;
        exp_q.delete();
        for (int i = 0; i + K <= n; i++) begin
            longint acc = 0;
            for (int j = 0; j < K; j++) acc += longint'($signed(data_q[i + j]));
            exp_q.push_back(SW'(acc));
        end
        got_q.delete();
        d0 = done_cnt;
        start(n);
        cycles = 1;
        while (done_cnt == d0 && cycles < 600) begin
            if (hold && !held && got_q.size() >= 1) begin
                clk_en = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 clk_en = 1'b1;
                held = 1'b1;
                cycles += 2;
            end
            @(posedge clk);
            #1 cycles++;
        end
        chk($sformatf("done_count_n%0d", n), 64'(done_cnt - d0), 64'd1);
        chk($sformatf("err_n%0d", n), 64'(last_err), 64'(n < K));
        chk($sformatf("sum_count_n%0d", n), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("sum%0d_n%0d", i, n), 64'(got_q[i]), 64'(exp_q[i]));
        chk($sformatf("pop1_total_n%0d", n), 64'(plus_ptr), 64'((n < K) ? 0 : n));
        chk($sformatf("pop2_total_n%0d", n), 64'(minus_ptr), 64'((n < K) ? 0 : n));
        chk($sformatf("busy_after_n%0d", n), 64'(ifc.Busy), 64'd0);
    endtask

    initial begin
        aclr = 1'b1;
        clk_en = 1'b1;
        ifc.Start = 1'b0;
        ifc.Length = 16'd0;
        foreach (stall_after[i]) stall_after[i] = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(ifc.Busy), 64'd0);
        chk("reset_sum", 64'(ifc.Sum), 64'd0);
        chk("reset_strobes", 64'({ifc.SumValid, ifc.Done, ifc.Err}), 64'd0);
        #1 aclr = 1'b0;

        // 1..6, N=6: sums 10, 14, 18.
        data_q.delete();
        for (int i = 1; i <= 6; i++) data_q.push_back(DW'(i));
        load();
        run_pass(6, 1'b0, base_cycles);
        chk("first_sum_literal", 64'(got_q.size() > 0 ? got_q[0] : '0), 64'd10);

        // Same data with plus-head stalls after the 2nd and 5th words.
        do_reset();
        stall_after[1] = 1'b1;
        stall_after[4] = 1'b1;
        run_pass(6, 1'b0, dummy);

        // N < K: rejected, Done/Err two cycles after Start, no pops.
        do_reset();
        data_q.delete();
        for (int i = 1; i <= 3; i++) data_q.push_back(DW'(i));
        load();
        got_q.delete();
        start(3);
        @(negedge clk);
        chk("reject_done_early", 64'(ifc.Done), 64'd0);
        @(negedge clk);
        chk("reject_done_err", 64'({ifc.Done, ifc.Err}), 64'd3);
        @(negedge clk);
        chk("reject_done_single", 64'(ifc.Done), 64'd0);
        chk("reject_no_pops", 64'(plus_ptr + minus_ptr), 64'd0);
        chk("reject_no_sums", 64'(got_q.size()), 64'd0);
        run_pass(0, 1'b0, dummy);

        // Signed data: -3, 5, -7, 2, 8 -> -3 then 8.
        do_reset();
        data_q.delete();
        data_q = {-32'sd3, 32'sd5, -32'sd7, 32'sd2, 32'sd8};
        load();
        run_pass(5, 1'b0, dummy);

        // Reset mid-SLIDE abandons the pass silently.
        do_reset();
        data_q.delete();
        for (int i = 1; i <= 6; i++) data_q.push_back(DW'(i));
        load();
        got_q.delete();
        start(6);
        for (int c = 0; c < 100 && got_q.size() == 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("aclr_reached_slide", 64'(got_q.size() > 0), 64'd1);
        dummy = done_cnt;
        aclr = 1'b1;
        @(posedge clk);
        #1 aclr = 1'b0;
        @(negedge clk);
        chk("aclr_busy", 64'(ifc.Busy), 64'd0);
        chk("aclr_sum", 64'(ifc.Sum), 64'd0);
        repeat (4) @(negedge clk);
        chk("aclr_no_done", 64'(done_cnt - dummy), 64'd0);
        data_q.delete();
        for (int i = 1; i <= 4; i++) data_q.push_back(DW'(i));
        load();
        run_pass(4, 1'b0, dummy);

        // clk_en low for 2 cycles mid-SLIDE: same sums, 2 cycles later.
        do_reset();
        data_q.delete();
        for (int i = 1; i <= 6; i++) data_q.push_back(DW'(i));
        load();
        run_pass(6, 1'b1, hold_cycles);
        chk("hold_delay", 64'(hold_cycles), 64'(base_cycles + 2));

        // Random lengths, data and stall positions.
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(0, 24);
            do_reset();
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(DW'($urandom));
            for (int i = 0; i + 1 < n; i++) stall_after[i] = ($urandom_range(0, 3) == 0);
            load();
            run_pass(n, t[0], dummy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
